// File: rtl/sig_monitor_pkg.sv
// Shared encodings for the signal conflict monitor: lamp states, fault codes,
// control states and the timing defaults.
package sig_monitor_pkg;

  typedef enum logic [1:0] {
    ST_UNK = 2'd0,
    ST_GRN = 2'd1,
    ST_YLW = 2'd2,
    ST_RED = 2'd3
  } lamp_st_e;

  typedef enum logic {
    CTRL_ARMED   = 1'b0,
    CTRL_FAULTED = 1'b1
  } ctrl_st_e;

  localparam logic [2:0] FC_NONE      = 3'd0;
  localparam logic [2:0] FC_CONFLICT  = 3'd1;
  localparam logic [2:0] FC_LAMP      = 3'd2;
  localparam logic [2:0] FC_SEQ       = 3'd3;
  localparam logic [2:0] FC_SHORT_YLW = 3'd4;
  localparam logic [2:0] FC_SHORT_AR  = 3'd5;

  localparam int YMIN_DEF  = 3;
  localparam int ARMIN_DEF = 1;

  localparam logic [3:0] CNT_MAX = 4'hF;

  function automatic logic legal_step(lamp_st_e from_st, lamp_st_e to_st);
    return (from_st == ST_GRN && to_st == ST_YLW) ||
           (from_st == ST_YLW && to_st == ST_RED) ||
           (from_st == ST_RED && to_st == ST_GRN);
  endfunction

  function automatic logic [3:0] sat_inc(logic [3:0] v);
    return (v == CNT_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/sig_lamp_tracker.sv
// Per-approach lamp tracker: follows the displayed colour, times yellow dwell
// and flags lamp faults and sequence/transition events for the monitor.
module sig_lamp_tracker
  import sig_monitor_pkg::*;
#(
  parameter int YMIN = YMIN_DEF
) (
  input  logic     clk,
  input  logic     clr,
  input  logic     grn,
  input  logic     ylw,
  input  logic     red,
  output lamp_st_e st,
  output logic     is_red,
  output logic     lamp_fault,
  output logic     seq_err,
  output logic     short_yel,
  output logic     red_to_grn
);

  localparam logic [3:0] YMIN_C = 4'(YMIN);

  lamp_st_e   st_q, st_d, col;
  logic [3:0] dwell_q, dwell_d;
  logic       inv_q, inv_d;
  logic       valid, chg;

  always_comb begin
    valid      = $onehot({grn, ylw, red});
    col        = grn ? ST_GRN : (ylw ? ST_YLW : ST_RED);
    st_d       = valid ? col : st_q;
    chg        = valid && (st_q != ST_UNK) && (col != st_q);
    seq_err    = chg && !legal_step(st_q, col);
    short_yel  = chg && (st_q == ST_YLW) && (col == ST_RED) && (dwell_q < YMIN_C);
    red_to_grn = chg && (st_q == ST_RED) && (col == ST_GRN);
    is_red     = valid && red;
    inv_d      = !valid;
    lamp_fault = inv_q && !valid;
    // dwell counts the loading edge, so entering yellow starts at 1
    if (st_d == ST_YLW) begin
      dwell_d = (st_q == ST_YLW) ? sat_inc(dwell_q) : 4'd1;
    end else begin
      dwell_d = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      st_q    <= ST_UNK;
      dwell_q <= 4'd0;
      inv_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      dwell_q <= dwell_d;
      inv_q   <= inv_d;
    end
  end

  assign st = st_q;

endmodule

// File: rtl/sig_monitor.sv
// Two-approach signal conflict monitor: all-red timing, fault priority and the
// latched fault FSM.
//   state        | meaning
//   CTRL_ARMED   | watching for violations, no fault latched
//   CTRL_FAULTED | fault latched, FCODE frozen until ACK with both approaches red
module sig_monitor
  import sig_monitor_pkg::*;
#(
  parameter int YMIN  = YMIN_DEF,
  parameter int ARMIN = ARMIN_DEF
) (
  input  logic       CK,
  input  logic       CLR,
  input  logic       GRN1,
  input  logic       YLW1,
  input  logic       RED1,
  input  logic       GRN2,
  input  logic       YLW2,
  input  logic       RED2,
  input  logic       TEST,
  input  logic       ACK,
  output logic       FAULT,
  output logic [2:0] FCODE,
  output logic       FLASH,
  output logic [1:0] ST1,
  output logic [1:0] ST2
);

  localparam logic [3:0] ARMIN_C = 4'(ARMIN);

  lamp_st_e   st1, st2;
  logic       red_a1, red_a2;
  logic       lf1, lf2, se1, se2, sy1, sy2, rg1, rg2;
  ctrl_st_e   state_q, state_d;
  logic [2:0] fcode_q, fcode_d;
  logic [3:0] ar_q, ar_d;
  logic       both_red, conflict, short_ar;
  logic [2:0] viol_code;

  sig_lamp_tracker #(.YMIN(YMIN)) u_trk1 (
    .clk(CK), .clr(CLR), .grn(GRN1), .ylw(YLW1), .red(RED1),
    .st(st1), .is_red(red_a1), .lamp_fault(lf1), .seq_err(se1),
    .short_yel(sy1), .red_to_grn(rg1)
  );

  sig_lamp_tracker #(.YMIN(YMIN)) u_trk2 (
    .clk(CK), .clr(CLR), .grn(GRN2), .ylw(YLW2), .red(RED2),
    .st(st2), .is_red(red_a2), .lamp_fault(lf2), .seq_err(se2),
    .short_yel(sy2), .red_to_grn(rg2)
  );

  always_comb begin
    both_red = red_a1 && red_a2;
    ar_d     = both_red ? sat_inc(ar_q) : 4'd0;
    conflict = (GRN1 || YLW1) && (GRN2 || YLW2);
    short_ar = (rg1 || rg2) && (ar_q < ARMIN_C);

    // lowest code wins; TEST only masks the timing checks
    if (conflict)                  viol_code = FC_CONFLICT;
    else if (lf1 || lf2)           viol_code = FC_LAMP;
    else if (se1 || se2)           viol_code = FC_SEQ;
    else if (!TEST && (sy1 || sy2)) viol_code = FC_SHORT_YLW;
    else if (!TEST && short_ar)    viol_code = FC_SHORT_AR;
    else                           viol_code = FC_NONE;

    state_d = state_q;
    fcode_d = fcode_q;
    case (state_q)
      CTRL_ARMED: begin
        if (viol_code != FC_NONE) begin
          state_d = CTRL_FAULTED;
          fcode_d = viol_code;
        end
      end
      CTRL_FAULTED: begin
        if (ACK && both_red) begin
          state_d = CTRL_ARMED;
          fcode_d = FC_NONE;
        end
      end
      default: begin
        state_d = CTRL_ARMED;
        fcode_d = FC_NONE;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (CLR) begin
      state_q <= CTRL_ARMED;
      fcode_q <= FC_NONE;
      ar_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      fcode_q <= fcode_d;
      ar_q    <= ar_d;
    end
  end

  assign FAULT = (state_q == CTRL_FAULTED);
  assign FLASH = FAULT;
  assign FCODE = fcode_q;
  assign ST1   = st1;
  assign ST2   = st2;

endmodule

// File: tb/tb_sig_monitor.sv
// Directed bench for sig_monitor with default YMIN=3, ARMIN=1.
module tb_sig_monitor;

  logic       CK = 1'b0;
  logic       CLR = 1'b0;
  logic       GRN1 = 1'b0, YLW1 = 1'b0, RED1 = 1'b1;
  logic       GRN2 = 1'b0, YLW2 = 1'b0, RED2 = 1'b1;
  logic       TEST = 1'b0, ACK = 1'b0;
  logic       FAULT, FLASH;
  logic [2:0] FCODE;
  logic [1:0] ST1, ST2;

  int tests = 0;
  int fails = 0;

  // pattern = {G1,Y1,R1,G2,Y2,R2}
  localparam logic [5:0] P_G1R2  = 6'b100_001;
  localparam logic [5:0] P_Y1R2  = 6'b010_001;
  localparam logic [5:0] P_RR    = 6'b001_001;
  localparam logic [5:0] P_R1G2  = 6'b001_100;
  localparam logic [5:0] P_G1G2  = 6'b100_100;
  localparam logic [5:0] P_RY1R2 = 6'b011_001;

  sig_monitor dut (
    .CK(CK), .CLR(CLR),
    .GRN1(GRN1), .YLW1(YLW1), .RED1(RED1),
    .GRN2(GRN2), .YLW2(YLW2), .RED2(RED2),
    .TEST(TEST), .ACK(ACK),
    .FAULT(FAULT), .FCODE(FCODE), .FLASH(FLASH),
    .ST1(ST1), .ST2(ST2)
  );

  always #5 CK = ~CK;

  task automatic cyc(input logic [5:0] pat, input logic clr_v, input logic ack_v);
    @(negedge CK);
    {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = pat;
    CLR = clr_v;
    ACK = ack_v;
    @(posedge CK);
    #1;
  endtask

  task automatic do_reset();
    TEST = 1'b0;
    cyc(P_RR, 1'b1, 1'b0);
    @(negedge CK);
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (FAULT !== 1'b0) begin fails++; $display("FAIL reset_fault got %0b want 0", FAULT); end
    tests++; if (FCODE !== 3'd0) begin fails++; $display("FAIL reset_fcode got %0d want 0", FCODE); end
    tests++; if (FLASH !== 1'b0) begin fails++; $display("FAIL reset_flash got %0b want 0", FLASH); end
    tests++; if ({ST1, ST2} !== 4'b0000) begin fails++; $display("FAIL reset_st got %0d/%0d want 0/0", ST1, ST2); end
  endtask

  task automatic test_legal_cycle();
    logic [5:0] pats [10];
    logic [1:0] e1 [10];
    logic [1:0] e2 [10];
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 5)       begin pats[i] = P_G1R2; e1[i] = 2'd1; e2[i] = 2'd3; end
      else if (i < 8)  begin pats[i] = P_Y1R2; e1[i] = 2'd2; e2[i] = 2'd3; end
      else if (i == 8) begin pats[i] = P_RR;   e1[i] = 2'd3; e2[i] = 2'd3; end
      else             begin pats[i] = P_R1G2; e1[i] = 2'd3; e2[i] = 2'd1; end
    end
    for (int i = 0; i < 10; i++) begin
      cyc(pats[i], 1'b0, 1'b0);
      tests++; if (FAULT !== 1'b0) begin fails++; $display("FAIL legal_fault edge %0d got %0b (code %0d) want 0", i, FAULT, FCODE); end
      tests++; if (ST1 !== e1[i] || ST2 !== e2[i]) begin fails++; $display("FAIL legal_st edge %0d got %0d/%0d want %0d/%0d", i, ST1, ST2, e1[i], e2[i]); end
    end
  endtask

  task automatic test_conflict_and_clr();
    do_reset();
    cyc(P_G1R2, 1'b0, 1'b0);
    cyc(P_G1G2, 1'b0, 1'b0);
    tests++; if (FAULT !== 1'b1 || FCODE !== 3'd1) begin fails++; $display("FAIL conflict got fault=%0b code=%0d want 1/1", FAULT, FCODE); end
    tests++; if (FLASH !== 1'b1) begin fails++; $display("FAIL conflict_flash got %0b want 1", FLASH); end
    cyc(P_RY1R2, 1'b0, 1'b0);
    cyc(P_RY1R2, 1'b0, 1'b0);
    tests++; if (FCODE !== 3'd1) begin fails++; $display("FAIL fcode_frozen got %0d want 1", FCODE); end
    cyc(P_G1G2, 1'b1, 1'b1);
    tests++; if (FAULT !== 1'b0 || FCODE !== 3'd0 || FLASH !== 1'b0) begin fails++; $display("FAIL clr_mid_fault got fault=%0b code=%0d flash=%0b want 0/0/0", FAULT, FCODE, FLASH); end
    tests++; if ({ST1, ST2} !== 4'b0000) begin fails++; $display("FAIL clr_st got %0d/%0d want 0/0", ST1, ST2); end
    cyc(P_Y1R2, 1'b0, 1'b0);
    tests++; if (FAULT !== 1'b0 || ST1 !== 2'd2 || ST2 !== 2'd3) begin fails++; $display("FAIL post_clr_load got fault=%0b st=%0d/%0d want 0 2/3", FAULT, ST1, ST2); end
  endtask

  task automatic test_lamp_fault();
    do_reset();
    cyc(P_RR, 1'b0, 1'b0);
    cyc(P_RY1R2, 1'b0, 1'b0);
    tests++; if (FAULT !== 1'b0 || ST1 !== 2'd3) begin fails++; $display("FAIL lamp_single got fault=%0b st1=%0d want 0/3", FAULT, ST1); end
    cyc(P_RR, 1'b0, 1'b0);
    cyc(P_RY1R2, 1'b0, 1'b0);
    tests++; if (FAULT !== 1'b0) begin fails++; $display("FAIL lamp_first got %0b want 0", FAULT); end
    cyc(P_RY1R2, 1'b0, 1'b0);
    tests++; if (FAULT !== 1'b1 || FCODE !== 3'd2) begin fails++; $display("FAIL lamp_second got fault=%0b code=%0d want 1/2", FAULT, FCODE); end
    cyc(P_RR, 1'b0, 1'b1);
    tests++; if (FAULT !== 1'b0 || FCODE !== 3'd0) begin fails++; $display("FAIL lamp_ack got fault=%0b code=%0d want 0/0", FAULT, FCODE); end
  endtask

  task automatic test_short_yellow();
    for (int t = 0; t < 2; t++) begin
      do_reset();
      TEST = (t == 1);
      cyc(P_G1R2, 1'b0, 1'b0);
      cyc(P_Y1R2, 1'b0, 1'b0);
      cyc(P_Y1R2, 1'b0, 1'b0);
      tests++; if (FAULT !== 1'b0) begin fails++; $display("FAIL short_ylw_pre test=%0d got %0b want 0", t, FAULT); end
      cyc(P_RR, 1'b0, 1'b0);
      if (t == 0) begin
        tests++; if (FAULT !== 1'b1 || FCODE !== 3'd4) begin fails++; $display("FAIL short_ylw got fault=%0b code=%0d want 1/4", FAULT, FCODE); end
      end else begin
        tests++; if (FAULT !== 1'b0 || ST1 !== 2'd3) begin fails++; $display("FAIL short_ylw_masked got fault=%0b st1=%0d want 0/3", FAULT, ST1); end
      end
    end
    TEST = 1'b0;
  endtask

  task automatic test_short_all_red();
    for (int t = 0; t < 2; t++) begin
      do_reset();
      TEST = (t == 1);
      cyc(P_G1R2, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(P_Y1R2, 1'b0, 1'b0);
      cyc(P_R1G2, 1'b0, 1'b0);
      if (t == 0) begin
        tests++; if (FAULT !== 1'b1 || FCODE !== 3'd5) begin fails++; $display("FAIL short_ar got fault=%0b code=%0d want 1/5", FAULT, FCODE); end
      end else begin
        tests++; if (FAULT !== 1'b0 || ST2 !== 2'd1) begin fails++; $display("FAIL short_ar_masked got fault=%0b st2=%0d want 0/1", FAULT, ST2); end
      end
    end
    TEST = 1'b0;
  endtask

  task automatic test_sequence_ack();
    do_reset();
    cyc(P_G1R2, 1'b0, 1'b0);
    cyc(P_R1G2, 1'b0, 1'b0);
    tests++; if (FAULT !== 1'b1 || FCODE !== 3'd3) begin fails++; $display("FAIL seq_prio got fault=%0b code=%0d want 1/3", FAULT, FCODE); end
    cyc(P_R1G2, 1'b0, 1'b1);
    tests++; if (FAULT !== 1'b1 || FCODE !== 3'd3) begin fails++; $display("FAIL ack_ignored got fault=%0b code=%0d want 1/3", FAULT, FCODE); end
    cyc(P_RR, 1'b0, 1'b1);
    tests++; if (FAULT !== 1'b0 || FCODE !== 3'd0 || FLASH !== 1'b0) begin fails++; $display("FAIL ack_clear got fault=%0b code=%0d flash=%0b want 0/0/0", FAULT, FCODE, FLASH); end
    tests++; if (ST1 !== 2'd3 || ST2 !== 2'd3) begin fails++; $display("FAIL ack_st got %0d/%0d want 3/3", ST1, ST2); end
    cyc(P_RR, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_legal_cycle();
    test_conflict_and_clr();
    test_lamp_fault();
    test_short_yellow();
    test_short_all_red();
    test_sequence_ack();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sig_monitor.md
SIG_MONITOR -- requirements
Module: sig_monitor

Interface
REQ-001 Parameter YMIN, default 3: minimum yellow dwell, in CK cycles.
REQ-002 Parameter ARMIN, default 1: minimum all-red clearance, in CK cycles.
REQ-003 CK  in  1  single clock; all state updates on the rising edge.
REQ-004 CLR  in  1  reset, synchronous, active-high.
REQ-005 GRN1, YLW1, RED1  in  1 each  approach-1 lamp drives from the signal controller.
REQ-006 GRN2, YLW2, RED2  in  1 each  approach-2 lamp drives from the signal controller.
REQ-007 TEST  in  1  when high, suppresses the timing checks (codes 4, 5).
REQ-008 ACK  in  1  operator fault clear.
REQ-009 FAULT  out  1  latched fault flag.
REQ-010 FCODE  out  3  latched fault cause; 0 = none.
REQ-011 FLASH  out  1  force-flash request to the cabinet; equals FAULT.
REQ-012 ST1, ST2  out  2 each  tracked approach state: 0=UNK, 1=GRN, 2=YLW, 3=RED.

Function
REQ-013 Lamp pattern per approach: valid when exactly one of G/Y/R is high; otherwise invalid.
REQ-014 Tracker: a valid pattern sampled at an edge loads ST to that colour; an invalid pattern holds ST.
REQ-015 First valid pattern after UNK loads with no sequence check.
REQ-016 Legal transitions are GRN->YLW, YLW->RED and RED->GRN only; any other change is code 3.
REQ-017 Yellow dwell: saturating 4-bit count of consecutive edges with ST=YLW, including the loading edge.
REQ-018 YLW->RED with dwell < YMIN is code 4.
REQ-019 All-red counter: saturating 4-bit count of consecutive edges with both sampled patterns RED.
REQ-020 RED->GRN on either approach with all-red count < ARMIN is code 5.
REQ-021 Conflict: both sampled patterns have G or Y high at the same edge; this is code 1, raised on that edge.
REQ-022 Lamp fault: an invalid pattern on either approach at two consecutive edges is code 2, raised on the second edge.
REQ-023 A single invalid edge raises no fault.
REQ-024 Control FSM states: ARMED, FAULTED.
REQ-025 ARMED -> FAULTED on the edge a violation is detected.
REQ-026 On that edge, FAULT=1 and FCODE is loaded.
REQ-027 Simultaneous violations: the lowest code wins.
REQ-028 In FAULTED, FCODE is frozen and further violations are ignored.
REQ-029 In FAULTED, trackers and counters keep running.
REQ-030 FAULTED -> ARMED on an edge with ACK=1 and both sampled patterns RED; FAULT and FCODE clear on that edge.
REQ-031 ACK in any other condition is ignored.
REQ-032 TEST=1 masks codes 4 and 5 only; codes 1, 2 and 3 remain active.

Reset
REQ-033 With CLR=1 at an edge: FAULT=0, FCODE=0, FLASH=0, ST1=ST2=UNK, all counters 0, lamp-fault history cleared, FSM=ARMED.
REQ-034 CLR overrides every other input at the same edge, including mid-fault and mid-dwell.

Structure
REQ-035 Shared package sig_monitor_pkg SHALL hold: the lamp-state encoding, the FCODE constants (1 conflict, 2 lamp, 3 sequence, 4 short yellow, 5 short all-red), and the YMIN/ARMIN defaults.
REQ-036 Sub-module sig_lamp_tracker, instantiated once per approach, SHALL hold ST, the yellow dwell counter, the invalid history, and the transition flags.
REQ-037 The all-red counter, violation priority logic, and FSM SHALL live in sig_monitor.

Verification
REQ-038 Legal cycle: G1/R2 for 5 edges, Y1 for 3, both R for 1, R1/G2 -> FAULT=0 throughout; ST1 follows 1,2,3 and ST2 shows 3 then 1.
REQ-039 GRN1 and GRN2 both high at one edge -> FAULT=1, FCODE=1 on that edge; FLASH=1.
REQ-040 RED1 and YLW1 high together: for 1 edge -> no fault; for 2 edges -> FCODE=2 on the second edge.
REQ-041 Y1 held 2 edges then R1 with TEST=0 -> FCODE=4; same stimulus with TEST=1 -> no fault.
REQ-042 Approach 1 goes GRN->RED directly while a code-5 condition is also present -> FCODE=3; ACK with approach 2 GRN is ignored; ACK with both RED -> FAULT=0 and FCODE=0 the next edge.
REQ-043 CLR asserted while FAULTED with FCODE=1 -> all outputs return to reset values at that edge; next valid pattern loads with no sequence check.
